// File: rtl/light_mon_pkg.sv
// Shared state, fault-code and lamp-encoding definitions for the traffic-light safety monitor.
package light_mon_pkg;

    typedef enum logic [1:0] {ST_ARM, ST_RUN, ST_FAULT} mon_state_e;

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_ONEHOT   = 3'd1;
    localparam logic [2:0] FC_CONFLICT = 3'd2;
    localparam logic [2:0] FC_ORDER    = 3'd3;
    localparam logic [2:0] FC_YSHORT   = 3'd4;
    localparam logic [2:0] FC_YLONG    = 3'd5;

    // Lamp vectors are packed {G, Y, R}.
    localparam logic [2:0] LAMP_G = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b001;

    function automatic logic lamp_onehot(input logic [2:0] l);
        return (l == LAMP_G) || (l == LAMP_Y) || (l == LAMP_R);
    endfunction

    function automatic logic lamp_step_ok(input logic [2:0] prev, input logic [2:0] cur);
        return (cur == prev)
            || ((prev == LAMP_G) && (cur == LAMP_Y))
            || ((prev == LAMP_Y) && (cur == LAMP_R))
            || ((prev == LAMP_R) && (cur == LAMP_G));
    endfunction

endpackage

// File: rtl/lamp_track.sv
// Per-road tracker: previous lamp state, encoding/order checks and the yellow-duration counter.
module lamp_track #(
    parameter int YEL_MIN = 2,
    parameter int YEL_MAX = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] lamps,
    input  logic       track_en,
    input  logic       ycnt_clr,
    output logic       onehot_err,
    output logic       order_err,
    output logic       yshort,
    output logic       ylong,
    output logic       r_to_g
);
    import light_mon_pkg::*;

    localparam logic [8:0] YMIN_LIM = 9'(YEL_MIN);
    localparam logic [8:0] YLONG_AT = 9'(YEL_MAX + 1);

    logic [2:0] prev_q, prev_d;
    logic [7:0] ycnt_q, ycnt_d, ycnt_inc;
    logic       is_y;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        is_y     = (lamps == LAMP_Y);
        ycnt_inc = sat_inc8(ycnt_q);
        prev_d   = prev_q;
        ycnt_d   = ycnt_q;
        if (ycnt_clr) begin
            ycnt_d = 8'd0;
        end else if (track_en) begin
            prev_d = lamps;
            ycnt_d = is_y ? ycnt_inc : 8'd0;
        end

        onehot_err = !lamp_onehot(lamps);
        order_err  = !lamp_step_ok(prev_q, lamps);
        // ycnt_q already includes every yellow sample before this red one.
        yshort     = (prev_q == LAMP_Y) && (lamps == LAMP_R) && ({1'b0, ycnt_q} < YMIN_LIM);
        ylong      = is_y && ({1'b0, ycnt_inc} >= YLONG_AT);
        r_to_g     = (prev_q == LAMP_R) && (lamps == LAMP_G);
    end

    // Previous-lamp register is always recaptured in ARM before it is used.
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ycnt_q <= 8'd0;
        end else begin
            ycnt_q <= ycnt_d;
        end
    end

endmodule

// File: rtl/light_monitor.sv
// Safety monitor for the two-road traffic-light controller: latches the first lamp violation
// and requests a flashing fail-safe; counts completed road-A cycles.
module light_monitor #(
    parameter int YEL_MIN   = 2,
    parameter int YEL_MAX   = 4,
    parameter int FLASH_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ga,
    input  logic       Ya,
    input  logic       Ra,
    input  logic       Gb,
    input  logic       Yb,
    input  logic       Rb,
    input  logic       clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash,
    output logic [7:0] cycles_done
);
    import light_mon_pkg::*;

    localparam int FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_DIV - 1);

    mon_state_e    state_q, state_d;
    logic          fault_q, fault_d;
    logic [2:0]    code_q, code_d;
    logic          flash_q, flash_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [7:0]    cycles_q, cycles_d;

    logic       track_en, ycnt_clr;
    logic       onehot_a, order_a, yshort_a, ylong_a, r_to_g_a;
    logic       onehot_b, order_b, yshort_b, ylong_b, r_to_g_b_unused;
    logic       conflict;
    logic [2:0] viol_code;

    assign track_en = (state_q != ST_FAULT);

    lamp_track #(.YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX)) u_track_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .lamps      ({Ga, Ya, Ra}),
        .track_en   (track_en),
        .ycnt_clr   (ycnt_clr),
        .onehot_err (onehot_a),
        .order_err  (order_a),
        .yshort     (yshort_a),
        .ylong      (ylong_a),
        .r_to_g     (r_to_g_a)
    );

    lamp_track #(.YEL_MIN(YEL_MIN), .YEL_MAX(YEL_MAX)) u_track_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .lamps      ({Gb, Yb, Rb}),
        .track_en   (track_en),
        .ycnt_clr   (ycnt_clr),
        .onehot_err (onehot_b),
        .order_err  (order_b),
        .yshort     (yshort_b),
        .ylong      (ylong_b),
        .r_to_g     (r_to_g_b_unused)
    );

    assign conflict = !Ra && !Rb;

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        code_d    = code_q;
        flash_d   = flash_q;
        fcnt_d    = fcnt_q;
        cycles_d  = cycles_q;
        ycnt_clr  = 1'b0;
        viol_code = FC_NONE;

        // Lowest code wins; order/duration checks only once the previous lamps are trusted.
        if (onehot_a || onehot_b) begin
            viol_code = FC_ONEHOT;
        end else if (conflict) begin
            viol_code = FC_CONFLICT;
        end else if (state_q == ST_RUN) begin
            if (order_a || order_b) begin
                viol_code = FC_ORDER;
            end else if (yshort_a || yshort_b) begin
                viol_code = FC_YSHORT;
            end else if (ylong_a || ylong_b) begin
                viol_code = FC_YLONG;
            end
        end

        case (state_q)
            ST_ARM, ST_RUN: begin
                if (viol_code != FC_NONE) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = viol_code;
                    flash_d = 1'b1;
                    fcnt_d  = '0;
                end else begin
                    state_d = ST_RUN;
                    if ((state_q == ST_RUN) && r_to_g_a) begin
                        cycles_d = cycles_q + 8'd1;
                    end
                end
            end
            ST_FAULT: begin
                if (clr) begin
                    state_d  = ST_ARM;
                    fault_d  = 1'b0;
                    code_d   = FC_NONE;
                    flash_d  = 1'b0;
                    fcnt_d   = '0;
                    ycnt_clr = 1'b1;
                end else if (fcnt_q == FLASH_LAST) begin
                    fcnt_d  = '0;
                    flash_d = !flash_q;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_ARM;
            fault_q  <= 1'b0;
            code_q   <= FC_NONE;
            flash_q  <= 1'b0;
            fcnt_q   <= '0;
            cycles_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            flash_q  <= flash_d;
            fcnt_q   <= fcnt_d;
            cycles_q <= cycles_d;
        end
    end

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign flash       = flash_q;
    assign cycles_done = cycles_q;

endmodule

// File: doc/light_monitor.md
# light_monitor

Independent safety monitor that reads the six lamp outputs of the two-road traffic-light controller, the opposite end of the controller's lamp interface. Each cycle it checks lamp encoding, cross-road conflicts, phase order and yellow duration. On the first violation it latches a fault code and drives a flashing fail-safe request. It also counts completed road-A cycles for statistics.

## Interface
- `YEL_MIN`, default 2: minimum legal yellow duration, in cycles.
- `YEL_MAX`, default 4: maximum legal yellow duration, in cycles. Must satisfy YEL_MIN ≤ YEL_MAX ≤ 254.
- `FLASH_DIV`, default 4: cycles per half-period of `flash`. Must be ≥ 1.
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `Ga`, `Ya`, `Ra` in 1 each: road A lamps, sampled from the controller.
- `Gb`, `Yb`, `Rb` in 1 each: road B lamps.
- `clr` in 1: synchronous, active-high fault clear.
- `fault` out 1: latched fault flag.
- `fault_code` out 3: first fault seen; 0 = none.
- `flash` out 1: fail-safe flash request; 0 unless in FAULT.
- `cycles_done` out 8: count of road-A R→G transitions.

## Operation
- **States:** ARM, RUN, FAULT. Reset enters ARM.
- **ARM**
  - Captures the current lamps as "previous".
  - Runs encoding and conflict checks only; no transition or duration checks.
  - Moves to RUN on the next edge if no fault is detected.
- **RUN:** all checks active. Per road, "previous" updates every cycle.
- **Fault codes** (lowest number wins when several occur on one edge):
  - 1 = road not one-hot: zero lamps or more than one lamp on.
  - 2 = conflict: neither Ra nor Rb is on.
  - 3 = illegal transition on either road. Legal per road: hold, G→Y, Y→R, R→G. Every other change is illegal.
  - 4 = yellow too short: a Y→R change occurs with yellow count < YEL_MIN.
  - 5 = yellow too long: yellow count reaches YEL_MAX+1.
- **Yellow counter** (per road, 8 bits)
  - Counts consecutive yellow samples, including the first.
  - Clears when yellow is not sampled.
  - Saturates at 255.
- **FAULT**
  - `fault` = 1; `fault_code` holds the first code.
  - All checks and `cycles_done` are frozen.
  - Later violations are ignored.
- **flash:** goes to 1 on FAULT entry, then toggles every FLASH_DIV cycles.
- **cycles_done:** increments once per road-A R→G change in RUN. Wraps 255→0.
- **clr**
  - From FAULT: clears `fault`, `fault_code`, `flash` and both yellow counters, then enters ARM.
  - In ARM or RUN: ignored.
  - `cycles_done` is not cleared by `clr`.

## Timing
- **Reset values:** `fault` = 0, `fault_code` = 0, `flash` = 0, `cycles_done` = 0, yellow counters = 0, state = ARM.
- **Latency:** a violation sampled at edge N shows `fault` and `fault_code` valid after edge N, i.e. 1 cycle. All outputs are registered.
- **clr while a violation is present:** clr wins on that edge. ARM then re-detects encoding and conflict faults on the following edge.
- **Reset mid-operation:** reset_n = 0 at any edge forces reset values regardless of state, and overrides clr.
- **Yellow-too-long:** with YEL_MAX = 4, the 5th consecutive yellow sample raises code 5 on that edge.

## Structure
- **Package `light_mon_pkg`:**
  - State enum: ARM, RUN, FAULT.
  - Fault code constants: NONE = 0, ONEHOT = 1, CONFLICT = 2, ORDER = 3, YSHORT = 4, YLONG = 5.
  - 3-bit lamp encoding: {G, Y, R}.
- **Sub-module `lamp_track`,** instantiated once per road.
  - Does: previous-lamp register, one-hot check, transition check, yellow counter.
  - Outputs: `onehot_err`, `order_err`, `yshort`, `ylong`, `r_to_g`.
- **Top level:** conflict check, priority encode, state machine, flash divider, cycle counter.

## Test plan
1. **Legal sequence:** reset. Drive A: G(5 cycles) → Y(3) → R, with B in R. Then B: G → Y(3) → R, with A in R. Then A R→G. Required: `fault` = 0 throughout; `cycles_done` = 1 one cycle after A re-enters G.
2. **Conflict:** Ga = 1 and Gb = 1 for one cycle. Required: `fault_code` = 2 next cycle; `flash` = 1, then toggles after 4 cycles.
3. **Simultaneous violations:** Ga = Ya = 1 while Gb = 1. Required: `fault_code` = 1, not 2.
4. **Order violation:** A goes G→R directly. Required: code 3. A later yellow-too-long event leaves the code at 3.
5. **Yellow duration:** yellow held 1 cycle then R → code 4. After clr, ARM, RUN: yellow held 5 cycles → code 5 on the 5th yellow sample.
6. **Reset and wrap:** reset_n pulsed low while in FAULT with clr = 1 → all outputs 0 next cycle. Then 256 legal A cycles → `cycles_done` returns to 0.
